// File: rtl/sobel_edge_3x3_8bit.sv
// -----------------------------------------------------------------------------
// sobel_edge_3x3_8bit
//
// Purpose:
//   3x3 Sobel edge detector for an 8-bit pixel stream. It builds a sliding
//   window from the two delayed-line taps of the line shift RAM plus the
//   current-line pixel, computes |Gx|+|Gy|, and thresholds the result into a
//   1-bit edge image. The frame sync signals are delayed by the same four
//   clocks as the data path so the output stream stays frame-aligned.
//
// Optional feature (macro SOBEL_GRAY_OUT_EN):
//   When defined, adds output post_img_gray carrying the magnitude saturated
//   to 8 bits (masked at the frame border). When undefined, that port and its
//   register do not exist and the bit path is unchanged.
//
// Parameters:
//   THRESH  edge threshold, bit = 1 when magnitude > THRESH (strict)
//   CNT_W   width of the column/row counters
//
// Ports:
//   clock             pixel clock, rising edge
//   rst_n             synchronous reset, active low
//   per_frame_vsync   input frame sync, active high
//   per_frame_href    input line valid, active high
//   per_frame_clken   input pixel valid strobe
//   row1_data         oldest line tap (two lines up)
//   row2_data         previous line tap (one line up)
//   row3_data         current line pixel
//   post_frame_vsync  vsync delayed 4 clocks
//   post_frame_href   href delayed 4 clocks
//   post_frame_clken  clken delayed 4 clocks
//   post_img_bit      edge decision for the window centre pixel
//   post_img_gray     saturated magnitude (SOBEL_GRAY_OUT_EN only)
// -----------------------------------------------------------------------------
module sobel_edge_3x3_8bit #(
   parameter logic [7:0]  THRESH = 8'd40,
   parameter int unsigned CNT_W  = 10
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       per_frame_vsync,
   input  logic       per_frame_href,
   input  logic       per_frame_clken,
   input  logic [7:0] row1_data,
   input  logic [7:0] row2_data,
   input  logic [7:0] row3_data,
   output logic       post_frame_vsync,
   output logic       post_frame_href,
   output logic       post_frame_clken,
   output logic       post_img_bit
`ifdef SOBEL_GRAY_OUT_EN
   ,
   output logic [7:0] post_img_gray
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   // ---------------------------------------------------------------------
   // Frame / line bookkeeping
   // ---------------------------------------------------------------------
   logic             vs_q;
   logic             href_q;
   logic             vs_rise;
   logic             href_fall;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic             win_ok_d;

   assign vs_rise   = per_frame_vsync & ~vs_q;
   assign href_fall = ~per_frame_href & href_q;

   // The row counter only advances once a vsync rising edge has been seen
   // since reset, so a mid-frame reset keeps the output masked until the
   // next frame starts.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      seen_d = seen_q;

      if (!per_frame_href) begin
         col_d = '0;
      end else if (per_frame_clken && (col_q != CNT_MAX)) begin
         col_d = col_q + CNT_ONE;
      end

      if (vs_rise) begin
         row_d  = '0;
         seen_d = 1'b1;
      end else if (href_fall && seen_q && (row_q != CNT_MAX)) begin
         row_d = row_q + CNT_ONE;
      end

      win_ok_d = (col_q >= CNT_TWO) && (row_q >= CNT_TWO);
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         vs_q   <= 1'b0;
         href_q <= 1'b0;
         seen_q <= 1'b0;
         col_q  <= '0;
         row_q  <= '0;
      end else begin
         vs_q   <= per_frame_vsync;
         href_q <= per_frame_href;
         seen_q <= seen_d;
         col_q  <= col_d;
         row_q  <= row_d;
      end
   end

   // ---------------------------------------------------------------------
   // S0: 3x3 window, shifts left on each pixel strobe
   // ---------------------------------------------------------------------
   logic [7:0] p11_q, p12_q, p13_q;
   logic [7:0] p21_q, p22_q, p23_q;
   logic [7:0] p31_q, p32_q, p33_q;
   logic       ok0_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         p11_q <= '0; p12_q <= '0; p13_q <= '0;
         p21_q <= '0; p22_q <= '0; p23_q <= '0;
         p31_q <= '0; p32_q <= '0; p33_q <= '0;
         ok0_q <= 1'b0;
      end else if (per_frame_clken) begin
         p11_q <= p12_q; p12_q <= p13_q; p13_q <= row1_data;
         p21_q <= p22_q; p22_q <= p23_q; p23_q <= row2_data;
         p31_q <= p32_q; p32_q <= p33_q; p33_q <= row3_data;
         ok0_q <= win_ok_d;
      end
   end

   // ---------------------------------------------------------------------
   // S1: signed gradients
   // ---------------------------------------------------------------------
   logic [9:0]         sxp_d, sxn_d, syp_d, syn_d;
   logic signed [10:0] gx_d, gy_d;
   logic signed [10:0] gx_q, gy_q;
   logic               ok1_q;

   always_comb begin
      sxp_d = {2'b00, p13_q} + {1'b0, p23_q, 1'b0} + {2'b00, p33_q};
      sxn_d = {2'b00, p11_q} + {1'b0, p21_q, 1'b0} + {2'b00, p31_q};
      syp_d = {2'b00, p31_q} + {1'b0, p32_q, 1'b0} + {2'b00, p33_q};
      syn_d = {2'b00, p11_q} + {1'b0, p12_q, 1'b0} + {2'b00, p13_q};
      gx_d  = $signed({1'b0, sxp_d}) - $signed({1'b0, sxn_d});
      gy_d  = $signed({1'b0, syp_d}) - $signed({1'b0, syn_d});
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         gx_q  <= '0;
         gy_q  <= '0;
         ok1_q <= 1'b0;
      end else begin
         gx_q  <= gx_d;
         gy_q  <= gy_d;
         ok1_q <= ok0_q;
      end
   end

   // ---------------------------------------------------------------------
   // S2: absolute values (|G| <= 1020 fits in 10 bits)
   // ---------------------------------------------------------------------
   logic [9:0] ax_d, ay_d;
   logic [9:0] ax_q, ay_q;
   logic       ok2_q;

   always_comb begin
      ax_d = gx_q[10] ? 10'(-gx_q) : 10'(gx_q);
      ay_d = gy_q[10] ? 10'(-gy_q) : 10'(gy_q);
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         ax_q  <= '0;
         ay_q  <= '0;
         ok2_q <= 1'b0;
      end else begin
         ax_q  <= ax_d;
         ay_q  <= ay_d;
         ok2_q <= ok1_q;
      end
   end

   // ---------------------------------------------------------------------
   // S3: magnitude, threshold, border mask
   // ---------------------------------------------------------------------
   logic [10:0] mag_d;
   logic        bit_d;
   logic        bit_q;

   always_comb begin
      mag_d = {1'b0, ax_q} + {1'b0, ay_q};
      bit_d = ok2_q && (mag_d > {3'b000, THRESH});
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign post_img_bit = bit_q;

`ifdef SOBEL_GRAY_OUT_EN
   logic [7:0] gray_d;
   logic [7:0] gray_q;

   always_comb begin
      gray_d = '0;
      if (ok2_q) begin
         gray_d = (mag_d > 11'd255) ? 8'hFF : mag_d[7:0];
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         gray_q <= '0;
      end else begin
         gray_q <= gray_d;
      end
   end

   assign post_img_gray = gray_q;
`else
   // Bit-only build: the magnitude is consumed solely by the threshold.
`endif

   // ---------------------------------------------------------------------
   // Sync delay lines, matched to the 4-stage data path
   // ---------------------------------------------------------------------
   logic [3:0] vs_dly_q;
   logic [3:0] href_dly_q;
   logic [3:0] clken_dly_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         vs_dly_q    <= '0;
         href_dly_q  <= '0;
         clken_dly_q <= '0;
      end else begin
         vs_dly_q    <= {vs_dly_q[2:0],    per_frame_vsync};
         href_dly_q  <= {href_dly_q[2:0],  per_frame_href};
         clken_dly_q <= {clken_dly_q[2:0], per_frame_clken};
      end
   end

   assign post_frame_vsync = vs_dly_q[3];
   assign post_frame_href  = href_dly_q[3];
   assign post_frame_clken = clken_dly_q[3];

endmodule
